// File: rtl/alu_mc.sv
// Multi-cycle integer ALU for the MIPS64 execute stage: single-cycle ops plus
// iterative radix-2 multiply and restoring divide behind a start/ready/done handshake.
package alu_mc_pkg;
    localparam int ALUOP_L = 5;
    typedef logic [ALUOP_L-1:0] aluop_t;

    localparam aluop_t OP_PASS = 5'd0;
    localparam aluop_t OP_ADD  = 5'd1;
    localparam aluop_t OP_ADDC = 5'd2;
    localparam aluop_t OP_SUB  = 5'd3;
    localparam aluop_t OP_SUBU = 5'd4;
    localparam aluop_t OP_SUBB = 5'd5;
    localparam aluop_t OP_INC  = 5'd6;
    localparam aluop_t OP_DEC  = 5'd7;
    localparam aluop_t OP_AND  = 5'd8;
    localparam aluop_t OP_OR   = 5'd9;
    localparam aluop_t OP_NOR  = 5'd10;
    localparam aluop_t OP_XOR  = 5'd11;
    localparam aluop_t OP_NEG  = 5'd12;
    localparam aluop_t OP_NOT  = 5'd13;
    localparam aluop_t OP_SLL  = 5'd14;
    localparam aluop_t OP_SRL  = 5'd15;
    localparam aluop_t OP_SLA  = 5'd16;
    localparam aluop_t OP_SRA  = 5'd17;
    localparam aluop_t OP_SLR  = 5'd18;
    localparam aluop_t OP_SRR  = 5'd19;
    localparam aluop_t OP_SEQ  = 5'd20;
    localparam aluop_t OP_SLT  = 5'd21;
    localparam aluop_t OP_SLTU = 5'd22;
    localparam aluop_t OP_MULT = 5'd23;
    localparam aluop_t OP_DIV  = 5'd24;
endpackage

module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int W = 32,
    localparam int SH_W = $clog2(W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ALUOP_L-1:0] op,
    input  logic               sgn,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               cin,
    output logic               ready,
    output logic               done,
    output logic [W-1:0]       y,
    output logic [W-1:0]       hi,
    output logic               zero,
    output logic               carry,
    output logic               ovf,
    output logic               divz,
    output logic               err
);
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_acc_hi, r_acc_lo, r_md;
    logic             r_is_div, r_neg_q, r_neg_r, r_ovf_pend;
    logic [W-1:0]     r_y, r_hi;
    logic             r_done, r_zero, r_carry, r_ovf, r_divz, r_err;

    logic             w_is_div, w_multi;
    logic [SH_W-1:0]  w_sh, w_nsh;
    logic [W:0]       w_add, w_inc, w_sub, w_dec;
    logic [W-1:0]     w_mag_a, w_mag_b;
    logic [W-1:0]     w_y, w_hi;
    logic             w_carry, w_ovf, w_divz, w_err;
    logic [W:0]       w_mul_sum, w_div_sh;
    logic             w_div_ge;
    logic [W-1:0]     w_div_rem, w_quo, w_rem;
    logic [2*W-1:0]   w_prod;

    assign w_is_div = (op == OP_DIV);
    assign w_multi  = (op == OP_MULT) || (w_is_div && (b != '0));

    assign w_sh  = b[SH_W-1:0];
    assign w_nsh = '0 - w_sh;  // (W - sh) mod W: rotate by 0 folds back to a | a
    assign w_add = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op == OP_ADDC) && cin};
    assign w_inc = {1'b0, a} + {{W{1'b0}}, 1'b1};
    assign w_sub = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, (op == OP_SUBB) && cin};
    assign w_dec = {1'b0, a} - {{W{1'b0}}, 1'b1};

    assign w_mag_a = (sgn && a[W-1]) ? ('0 - a) : a;
    assign w_mag_b = (sgn && b[W-1]) ? ('0 - b) : b;

    always_comb begin
        // NOTE: every output gets a default first so no opcode path infers a latch.
        w_y = '0; w_hi = '0; w_carry = 1'b0; w_ovf = 1'b0; w_divz = 1'b0; w_err = 1'b0;
        case (op)
            OP_PASS: w_y = a;
            OP_ADD, OP_ADDC: begin
                w_y     = w_add[W-1:0];
                w_carry = w_add[W];
                w_ovf   = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
            end
            OP_INC: begin w_y = w_inc[W-1:0]; w_carry = w_inc[W]; end
            OP_SUB, OP_SUBB: begin
                w_y     = w_sub[W-1:0];
                w_carry = w_sub[W];
                w_ovf   = (a[W-1] != b[W-1]) && (w_sub[W-1] != a[W-1]);
            end
            OP_SUBU: begin w_y = w_sub[W-1:0]; w_carry = w_sub[W]; end
            OP_DEC:  begin w_y = w_dec[W-1:0]; w_carry = w_dec[W]; end
            OP_AND:  w_y = a & b;
            OP_OR:   w_y = a | b;
            OP_NOR:  w_y = ~(a | b);
            OP_XOR:  w_y = a ^ b;
            OP_NEG:  begin w_y = '0 - a; w_ovf = (a == MIN_V); end
            OP_NOT:  w_y = ~a;
            OP_SLL, OP_SLA: w_y = a << w_sh;
            OP_SRL:  w_y = a >> w_sh;
            OP_SRA:  w_y = $signed(a) >>> w_sh;
            OP_SLR:  w_y = (a << w_sh) | (a >> w_nsh);
            OP_SRR:  w_y = (a >> w_sh) | (a << w_nsh);
            OP_SEQ:  w_y = {{(W-1){1'b0}}, (a == b) ^ cin};
            OP_SLT:  w_y = {{(W-1){1'b0}}, ($signed(a) < $signed(b)) ^ cin};
            OP_SLTU: w_y = {{(W-1){1'b0}}, (a < b) ^ cin};
            OP_MULT: ;
            OP_DIV: begin
                w_y = '1; w_hi = a; w_divz = 1'b1;  // only reached with b == 0
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_md} : '0);
    assign w_div_sh  = {r_acc_hi, r_acc_lo[W-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_md});
    assign w_div_rem = w_div_ge ? (w_div_sh[W-1:0] - r_md) : w_div_sh[W-1:0];

    assign w_quo  = r_neg_q ? ('0 - r_acc_lo) : r_acc_lo;
    assign w_rem  = r_neg_r ? ('0 - r_acc_hi) : r_acc_hi;
    assign w_prod = r_neg_q ? ('0 - {r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && w_multi) w_next = S_ITER;
            S_ITER:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the iteration registers are cleared too, so an aborted op leaves nothing behind.
            r_cnt <= '0; r_acc_hi <= '0; r_acc_lo <= '0; r_md <= '0;
            r_is_div <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_ovf_pend <= 1'b0;
            r_y <= '0; r_hi <= '0; r_done <= 1'b0;
            r_zero <= 1'b0; r_carry <= 1'b0; r_ovf <= 1'b0; r_divz <= 1'b0; r_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    if (w_multi) begin
                        r_cnt      <= CNT_W'(W);
                        r_acc_hi   <= '0;
                        r_acc_lo   <= w_mag_a;
                        r_md       <= w_mag_b;
                        r_is_div   <= w_is_div;
                        r_neg_q    <= sgn && (a[W-1] ^ b[W-1]);
                        r_neg_r    <= sgn && a[W-1];
                        r_ovf_pend <= w_is_div && sgn && (a == MIN_V) && (&b);
                    end else begin
                        r_y <= w_y; r_hi <= w_hi; r_zero <= (w_y == '0);
                        r_carry <= w_carry; r_ovf <= w_ovf; r_divz <= w_divz; r_err <= w_err;
                        r_done <= 1'b1;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_is_div) begin
                        r_acc_hi <= w_div_rem;
                        r_acc_lo <= {r_acc_lo[W-2:0], w_div_ge};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[W-1:1]};
                    end
                end
                S_FIX: begin
                    r_y    <= r_is_div ? w_quo : w_prod[W-1:0];
                    r_hi   <= r_is_div ? w_rem : w_prod[2*W-1:W];
                    r_zero <= r_is_div ? (w_quo == '0) : (w_prod[W-1:0] == '0);
                    r_carry <= 1'b0; r_ovf <= r_ovf_pend; r_divz <= 1'b0; r_err <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign done  = r_done;
    assign y     = r_y;
    assign hi    = r_hi;
    assign zero  = r_zero;
    assign carry = r_carry;
    assign ovf   = r_ovf;
    assign divz  = r_divz;
    assign err   = r_err;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at W=32: hand-computed vectors covering flags,
// multi-cycle latency, ignored starts, divide corner cases and mid-op reset.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [ALUOP_L-1:0] op = '0;
    logic               sgn = 1'b0;
    logic [W-1:0]       a = '0;
    logic [W-1:0]       b = '0;
    logic               cin = 1'b0;
    logic               ready, done, zero, carry, ovf, divz, err;
    logic [W-1:0]       y, hi;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_mc #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn),
        .a(a), .b(b), .cin(cin), .ready(ready), .done(done),
        .y(y), .hi(hi), .zero(zero), .carry(carry), .ovf(ovf),
        .divz(divz), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one start pulse; returns 1 ns after the accepting edge.
    task automatic issue(input logic [ALUOP_L-1:0] o, input logic s,
                         input logic [W-1:0] xa, input logic [W-1:0] xb, input logic c);
        op = o; sgn = s; a = xa; b = xb; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int rdy_bad;
        int seen;

        #2;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_yhi", {hi, y}, 64'd0);
        chk("rst_flags", 64'({done, zero, carry, ovf, divz, err}), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // flags packed as {zero, carry, ovf, divz, err}
        issue(OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("add_done", 64'(done), 64'd1);
        chk("add_y", 64'(y), 64'd0);
        chk("add_flags", 64'({zero, carry, ovf, divz, err}), 64'b11000);
        @(posedge clk); #1;
        chk("add_done_pulse", 64'({done, y}), 64'd0);

        issue(OP_SUB, 1'b0, 32'h8000_0000, 32'd1, 1'b0);
        chk("sub_y", 64'(y), 64'h7FFF_FFFF);
        chk("sub_flags", 64'({zero, carry, ovf, divz, err}), 64'b00100);

        issue(OP_SUBU, 1'b0, 32'd0, 32'd1, 1'b0);
        chk("subu_y", 64'(y), 64'hFFFF_FFFF);
        chk("subu_flags", 64'({zero, carry, ovf, divz, err}), 64'b01000);

        issue(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_busy", 64'(ready), 64'd0);
        n = 0; rdy_bad = 0;
        while (done !== 1'b1 && n < 200) begin
            if (n == 4) begin a = 32'd123; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done !== 1'b1 && ready !== 1'b0) rdy_bad++;
        end
        start = 1'b0;
        chk("mult_latency", 64'(n), 64'd33);
        chk("mult_ready_low", 64'(rdy_bad), 64'd0);
        chk("mult_ready_done", 64'(ready), 64'd1);
        chk("mult_prod", {hi, y}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_flags", 64'({zero, carry, ovf, divz, err}), 64'b00000);
        @(posedge clk); #1;
        chk("mult_no_requeue", 64'({done, ready}), 64'b01);

        issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(n);
        chk("div_latency", 64'(n), 64'd33);
        chk("div_res", {hi, y}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0);
        chk("divz_done", 64'(done), 64'd1);
        chk("divz_res", {hi, y}, 64'hFFFF_FFF9_FFFF_FFFF);
        chk("divz_flags", 64'({zero, carry, ovf, divz, err}), 64'b00010);

        issue(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        chk("divmin_res", {hi, y}, 64'h0000_0000_8000_0000);
        chk("divmin_flags", 64'({zero, carry, ovf, divz, err}), 64'b00100);

        issue(OP_ADD, 1'b0, 32'd10, 32'd20, 1'b0);
        chk("b2b_done", 64'(done), 64'd1);
        chk("b2b_y", 64'(y), 64'd30);

        issue(OP_SRR, 1'b0, 32'h8000_0001, 32'd0, 1'b0);
        chk("srr0_y", 64'(y), 64'h8000_0001);
        issue(OP_SRR, 1'b0, 32'h8000_0001, 32'd4, 1'b0);
        chk("srr4_y", 64'(y), 64'h1800_0000);
        issue(OP_SRA, 1'b0, 32'h8000_0000, 32'd4, 1'b0);
        chk("sra_y", 64'(y), 64'hF800_0000);

        issue(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        chk("slt_cin0", 64'(y), 64'd1);
        issue(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        chk("slt_cin1", 64'({y, zero}), 64'd1);
        issue(OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        chk("sltu_y", 64'(y), 64'd0);

        issue(5'd31, 1'b0, 32'h1234_5678, 32'd9, 1'b0);
        chk("unk_res", {hi, y}, 64'd0);
        chk("unk_flags", 64'({zero, carry, ovf, divz, err}), 64'b10001);

        issue(OP_ADD, 1'b0, 32'd5, 32'd6, 1'b0);
        issue(OP_MULT, 1'b0, 32'd3, 32'd5, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        chk("rstmid_busy", 64'(ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_ready", 64'(ready), 64'd1);
        chk("rstmid_yhi", {hi, y}, 64'd0);
        chk("rstmid_flags", 64'({done, zero, carry, ovf, divz, err}), 64'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        chk("rstmid_no_done", 64'(seen), 64'd0);

        issue(OP_ADD, 1'b0, 32'd2, 32'd3, 1'b0);
        chk("post_rst_done", 64'(done), 64'd1);
        chk("post_rst_y", 64'(y), 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle integer ALU for the MIPS64 execute stage. It performs all single-cycle operations of the team ALU opcode set in one clock. It adds iterative multiply and divide with a full double-width result, status flags, and a clocked start/ready/done handshake that replaces the edge-triggered run/ack scheme. The EX-stage controller drives one operation at a time and stalls on `ready`.

## Interface
- `W`, 32: operand width; power of two, 8..64.
- `SH_W`, $clog2(W): shift-amount width, derived, not overridden.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only on an edge where `ready`=1.
- `op`  in  `ALUOP_L`  opcode from the team ALU opcode header.
- `sgn`  in  1  MULT/DIV: 1 = signed operands, 0 = unsigned.
- `a`, `b`  in  W  operands, sampled on accept.
- `cin`  in  1  carry/borrow in; inversion select for compares.
- `ready`  out  1  block idle, can accept.
- `done`  out  1  one-cycle pulse: `y`/`hi`/flags valid.
- `y`  out  W  result; MULT low half; DIV quotient.
- `hi`  out  W  MULT high half; DIV remainder; 0 for other ops.
- `zero`, `carry`, `ovf`, `divz`, `err`  out  1 each  status flags.

## Operation
- FSM states: IDLE, ITER, FIX. `ready` = (state==IDLE).
- Accept: `a`, `b`, `op`, `sgn`, `cin` are registered. Later input changes are ignored until the next accept.
- Single-cycle ops stay in IDLE. Results are registered on the accept edge.
  - PASS/ADD/ADDC/SUB/SUBU/SUBB/INC/DEC/AND/OR/NOR/XOR/NEG/NOT: W-bit wrap-around arithmetic.
  - SLL/SRL/SLA/SRA: shift amount is `b[SH_W-1:0]`.
  - SLR/SRR: rotates; amount 0 returns `a` unchanged.
  - SEQ/SLT/SLTU: `y` = zero-extended (cond ^ cin). SLT is signed.
- Flags:
  - `zero` = (y==0) for every op.
  - `carry`, ADD/ADDC/INC: bit W of the (W+1)-bit sum.
  - `carry`, SUB/SUBU/SUBB/DEC: 1 on borrow.
  - `carry` = 0 for all other ops.
  - `ovf`: signed overflow for ADD/ADDC/SUB/SUBB/NEG; 0 otherwise. SUBU never sets `ovf`.
- MULT: IDLE→ITER with counter=W.
  - ITER runs radix-2 shift-add on operand magnitudes (magnitudes taken when `sgn`=1), one bit per cycle, counter decrements.
  - At counter 1 → FIX. FIX negates the 2W product if `sgn` and the operand signs differ, then → IDLE with `done`.
  - `{hi,y}` = full 2W product.
- DIV: same path with restoring division on magnitudes.
  - Quotient truncates toward zero. Remainder takes the dividend's sign.
  - Signed MIN/−1: `y`=MIN, `hi`=0, `ovf`=1.
- DIV with `b`==0: no ITER. Completes like a single-cycle op with `divz`=1, `y`=all ones, `hi`=`a`.
- Unknown `op`: single-cycle completion with `y`=0, `hi`=0, `err`=1.
- `start` while `ready`=0: ignored, no queueing.
- Reset (async, any state, including mid-ITER): state=IDLE, counter=0.
  - All outputs = 0 except `ready`=1.
  - The in-flight operation is discarded; no `done` is produced for it.

## Timing
- Single-cycle op: accepted on edge k. `done`=1 and results are valid in the cycle after edge k.
- MULT/DIV: accepted on edge k. ITER covers edges k+1..k+W, FIX is edge k+W+1. `done` is high for the one cycle after edge k+W+1, so latency is W+1 cycles.
- `ready` = 0 from after edge k until the FIX edge. `ready` = 1 in the `done` cycle.
- Back-to-back: a `start` in the `done` cycle is accepted.
- `y`, `hi` and flags hold their values until the next completion. `done` is low in all other cycles.
- No combinational path from inputs to outputs.

## Test plan
- ADD, W=32, a=0xFFFFFFFF, b=1 → `y`=0, `carry`=1, `zero`=1, `ovf`=0, `done` one cycle after accept; then SUB a=0x80000000, b=1 → `y`=0x7FFFFFFF, `ovf`=1.
- MULT, `sgn`=1, a=0xFFFFFFFD, b=7 → `hi`=0xFFFFFFFF, `y`=0xFFFFFFEB, `done` exactly 33 cycles after accept; `ready`=0 throughout; a `start` pulse with changed `a` at cycle 5 has no effect.
- DIV, `sgn`=1, a=0xFFFFFFF9, b=2 → `y`=0xFFFFFFFD, `hi`=0xFFFFFFFF; then b=0 → `divz`=1, `y`=0xFFFFFFFF, `hi`=a after 1 cycle; then a=0x80000000, b=0xFFFFFFFF → `y`=0x80000000, `ovf`=1.
- SRR a=0x80000001, b=0 → `y`=0x80000001; b=4 → `y`=0x18000000; SLT a=−1, b=0 with `cin`=0 → `y`=1, with `cin`=1 → `y`=0.
- `rst` pulsed during MULT ITER at cycle 10 → all outputs 0 and `ready`=1 immediately, no later `done`; after release, ADD 2+3 → `y`=5.
- Back-to-back: DIV `done` cycle carries a new ADD `start` → ADD `done` on the next cycle. Unknown opcode → `err`=1, `y`=0.
